// File: rtl/genesis3_pkg.sv
// genesis3_pkg: shared saturation mode encodings and step zero-extension helper
package genesis3_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] zext_step(input logic [MAX_W-1:0] step, input int unsigned width);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = (i < int'(width)) ? step[i] : 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/carry_chain_add.sv
// carry_chain_add: ripple carry adder built from per-bit propagate/generate cells
module carry_chain_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  assign cout = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p, g;
    assign p = A[i] ^ B[i];
    assign g = A[i] & B[i];
    assign c[i+1] = p ? c[i] : g;
    assign sum[i] = p ^ c[i];
  end
endmodule

// File: rtl/carry_chain_counter.sv
// carry_chain_counter: registered up/down counter on a ripple carry chain with load, step and saturation
module carry_chain_counter
  import genesis3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP_WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  E,
  input  logic                  LD,
  input  logic [WIDTH-1:0]      D,
  input  logic                  DIR,
  input  logic [STEP_WIDTH-1:0] STEP,
  output logic [WIDTH-1:0]      Q,
  output logic                  CO,
  output logic                  TC
);
  logic [WIDTH-1:0] stp, b, sum, nq;
  logic cout, wrap;
  assign stp = WIDTH'(zext_step(MAX_W'(STEP), STEP_WIDTH));
  assign b = DIR ? ~stp : stp;
  carry_chain_add #(.WIDTH(WIDTH)) u_add (.A(Q), .B(b), .cin(DIR), .sum(sum), .cout(cout));
  assign wrap = DIR ? ~cout : cout;
  assign TC = DIR ? (Q == '0) : (&Q);
  // next count value: wrapped chain sum, or clamped to the rail in saturating mode
  always_comb begin
    nq = (SATURATE == MODE_SAT && wrap) ? (DIR ? '0 : '1) : sum;
  end
  // register bank with reset > load > count priority
  always_ff @(posedge C) begin
    if (R) begin
      Q <= INIT_VALUE;
      CO <= 1'b0;
    end else if (LD) begin
      Q <= D;
      CO <= 1'b0;
    end else if (E) begin
      Q <= nq;
      CO <= wrap;
    end
  end
endmodule

// File: tb/tb_carry_chain_counter.sv
// tb_carry_chain_counter: randomized and directed checks of wrap and saturating counters against an arithmetic model
module tb_carry_chain_counter;
  logic C = 0, R = 1, E = 0, LD = 0, DIR = 0;
  logic [7:0] D = 0;
  logic [3:0] STEP = 0;
  logic [7:0] q0, q1;
  logic co0, co1, tc0, tc1;
  logic [7:0] m0, m1;
  logic mc0, mc1;
  logic chk_en = 0;
  int checks = 0, errors = 0;

  always #5 C = ~C;

  carry_chain_counter #(.WIDTH(8), .STEP_WIDTH(4), .INIT_VALUE(8'h05), .SATURATE(0)) dut0 (
    .C(C), .R(R), .E(E), .LD(LD), .D(D), .DIR(DIR), .STEP(STEP), .Q(q0), .CO(co0), .TC(tc0));
  carry_chain_counter #(.WIDTH(8), .STEP_WIDTH(4), .INIT_VALUE(8'h05), .SATURATE(1)) dut1 (
    .C(C), .R(R), .E(E), .LD(LD), .D(D), .DIR(DIR), .STEP(STEP), .Q(q1), .CO(co1), .TC(tc1));

  function automatic logic [8:0] model_next(input logic [7:0] q, input logic sat, input logic dn, input logic [3:0] s);
    int t;
    logic w;
    t = dn ? int'(q) - int'(s) : int'(q) + int'(s);
    w = (t < 0) || (t > 255);
    return {w, (sat && w) ? (dn ? 8'h00 : 8'hFF) : 8'(t)};
  endfunction

  always @(posedge C) begin
    if (R) begin
      m0 <= 8'h05; mc0 <= 0; m1 <= 8'h05; mc1 <= 0;
    end else if (LD) begin
      m0 <= D; mc0 <= 0; m1 <= D; mc1 <= 0;
    end else if (E) begin
      {mc0, m0} <= model_next(m0, 1'b0, DIR, STEP);
      {mc1, m1} <= model_next(m1, 1'b1, DIR, STEP);
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge C) begin
    if (chk_en) begin
      chk("model q0", int'(q0), int'(m0));
      chk("model co0", int'(co0), int'(mc0));
      chk("model tc0", int'(tc0), int'(DIR ? (m0 == 8'h00) : (m0 == 8'hFF)));
      chk("model q1", int'(q1), int'(m1));
      chk("model co1", int'(co1), int'(mc1));
      chk("model tc1", int'(tc1), int'(DIR ? (m1 == 8'h00) : (m1 == 8'hFF)));
    end
  end

  task automatic cyc(input logic r, input logic ld, input logic e, input logic dn, input logic [3:0] s, input logic [7:0] d);
    R = r; LD = ld; E = e; DIR = dn; STEP = s; D = d;
    @(posedge C);
    @(negedge C);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    chk("reset q0", int'(q0), 8'h05);
    chk("reset co0", int'(co0), 0);
    chk("reset q1", int'(q1), 8'h05);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("hold q0", int'(q0), 8'h05);
    cyc(0, 1, 0, 0, 0, 8'hFE);
    cyc(0, 0, 1, 0, 1, 0);
    chk("up1 q0", int'(q0), 8'hFF); chk("up1 co0", int'(co0), 0); chk("up1 tc0", int'(tc0), 1);
    cyc(0, 0, 1, 0, 1, 0);
    chk("up2 q0", int'(q0), 8'h00); chk("up2 co0", int'(co0), 1); chk("up2 tc0", int'(tc0), 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("up3 q0", int'(q0), 8'h01); chk("up3 co0", int'(co0), 0); chk("up3 tc0", int'(tc0), 0);
    cyc(0, 1, 0, 1, 0, 8'h02);
    cyc(0, 0, 1, 1, 3, 0);
    chk("dn1 q0", int'(q0), 8'hFF); chk("dn1 co0", int'(co0), 1);
    cyc(0, 0, 1, 1, 3, 0);
    chk("dn2 q0", int'(q0), 8'hFC); chk("dn2 co0", int'(co0), 0);
    cyc(0, 1, 0, 0, 0, 8'hFA);
    cyc(0, 0, 1, 0, 9, 0);
    chk("sat1 q1", int'(q1), 8'hFF); chk("sat1 co1", int'(co1), 1);
    cyc(0, 0, 1, 0, 9, 0);
    chk("sat2 q1", int'(q1), 8'hFF); chk("sat2 co1", int'(co1), 1);
    cyc(0, 1, 0, 1, 0, 8'h04);
    cyc(0, 0, 1, 1, 5, 0);
    chk("satdn q1", int'(q1), 8'h00); chk("satdn co1", int'(co1), 1); chk("satdn tc1", int'(tc1), 1);
    cyc(0, 0, 1, 1, 0, 0);
    chk("step0 dn q1", int'(q1), 8'h00); chk("step0 dn co1", int'(co1), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("step0 up co0", int'(co0), 0);
    cyc(1, 1, 1, 0, 1, 8'hAA);
    chk("prio r q0", int'(q0), 8'h05); chk("prio r q1", int'(q1), 8'h05);
    cyc(0, 1, 1, 0, 1, 8'h3C);
    chk("prio ld q0", int'(q0), 8'h3C); chk("prio ld co0", int'(co0), 0);
    cyc(0, 1, 0, 0, 0, 8'h10);
    cyc(0, 0, 1, 0, 2, 0);
    chk("mid1 q0", int'(q0), 8'h12);
    cyc(0, 0, 1, 0, 2, 0);
    chk("mid2 q0", int'(q0), 8'h14);
    cyc(1, 0, 1, 0, 2, 0);
    chk("mid rst q0", int'(q0), 8'h05);
    cyc(0, 0, 1, 0, 2, 0);
    chk("mid resume q0", int'(q0), 8'h07);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), 4'($urandom), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/carry_chain_counter.md
Name: carry_chain_counter

Overview:
- Parametrised registered up/down counter and accumulator for genesis3 fabric mapping.
- Built from a ripple carry chain: per-bit propagate/generate (p, g), sumout = p ^ cin, cout = p ? cin : g. The chain drives a bank of enable flip-flops.
- Successor to the single-bit carry cell plus DFF pair. Adds width generalisation, load, direction, step size, saturation mode and terminal-count/overflow flags.
- Used as the simulation model for inferred counters and accumulators mapped onto the carry chain.

Parameters:
- WIDTH, 8, counter/accumulator width in bits (>= 2).
- STEP_WIDTH, 1, width of the STEP increment input (1..WIDTH).
- INIT_VALUE, 0, value Q takes on reset (WIDTH bits).
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at all-ones (up) or zero (down).

Ports:
- C  input  1  clock, rising edge.
- R  input  1  reset, synchronous, active-high.
- E  input  1  count enable, active-high.
- LD  input  1  synchronous load, active-high.
- D  input  WIDTH  load value.
- DIR  input  1  0 = up (add), 1 = down (subtract).
- STEP  input  STEP_WIDTH  increment magnitude, zero-extended to WIDTH.
- Q  output  WIDTH  registered count.
- CO  output  1  registered carry/borrow-out of the last count operation.
- TC  output  1  combinational terminal count: Q == all-ones when DIR=0, Q == 0 when DIR=1.

Behaviour:
- All state updates on posedge C. Priority: R > LD > E.
- Reset (R=1 at edge): Q <= INIT_VALUE, CO <= 0. R is sampled only at the edge; asserting R mid-operation takes effect on the next edge, and E/LD are ignored that cycle.
- Load (LD=1, R=0): Q <= D, CO <= 0, regardless of E.
- Count (E=1, LD=0, R=0), one-cycle latency:
  - Operand B = zero-extended STEP when DIR=0; bitwise inverse of zero-extended STEP when DIR=1. Chain cin = DIR.
  - Per bit i: p[i] = Q[i] ^ B[i], g[i] = Q[i] & B[i], c[i+1] = p[i] ? c[i] : g[i], sum[i] = p[i] ^ c[i].
  - cout = c[WIDTH]. Up overflow: cout = 1. Down borrow: cout = 0.
- SATURATE=0: Q <= sum. CO <= cout when up, ~cout when down, so CO=1 means wrap occurred.
- SATURATE=1: on up overflow, Q <= all-ones. On down borrow, Q <= 0. CO <= 1 when clamping occurred, else 0.
- Hold (E=0, LD=0, R=0): Q and CO unchanged.
- STEP=0 with E=1: Q unchanged, CO <= 0. Down with STEP=0 gives cout=1, so no borrow.
- TC follows Q and DIR combinationally; no latency.
- No initial-block initialisation; reset alone defines state. Reset values: Q=INIT_VALUE, CO=0. TC is then derived.

Decomposition:
- Shared package genesis3_pkg:
  - localparam for the saturation mode encodings (MODE_WRAP=0, MODE_SAT=1).
  - Function zext_step(STEP, WIDTH).
- One natural sub-module, carry_chain_add:
  - Parametrised WIDTH ripple adder with inputs A, B, cin and outputs sum, cout.
  - Generate-loop of per-bit p/g cells.
  - Reused by future accumulator and comparator blocks.
- Top module holds the register bank, priority mux and saturation clamp.

Test Plan (WIDTH=8, STEP_WIDTH=4):
- Reset/hold: INIT_VALUE=8'h05, R=1 one cycle -> Q=8'h05, CO=0. Then E=0 for 3 cycles -> Q stays 8'h05.
- Up wrap, SATURATE=0: LD D=8'hFE, then E=1, DIR=0, STEP=1 for 3 cycles -> Q=FF, 00, 01 and CO=0, 1, 0. TC=1 only while Q=FF.
- Down borrow, SATURATE=0: LD D=8'h02, E=1, DIR=1, STEP=3 -> Q=8'hFF, CO=1. Next cycle Q=8'hFC, CO=0.
- Saturate, SATURATE=1:
  - LD 8'hFA, up STEP=9 -> Q=FF, CO=1; again -> Q=FF, CO=1.
  - LD 8'h04, down STEP=5 -> Q=00, CO=1.
- Priority: same edge R=1, LD=1, E=1 -> Q=INIT_VALUE. Next edge LD=1 (D=8'h3C) with E=1 -> Q=8'h3C, CO=0, no increment.
- Mid-count reset: counting up by 2 from 8'h10; R pulsed at cycle 3 -> Q=INIT_VALUE that edge. Counting resumes from INIT_VALUE next edge (INIT_VALUE+2).
